// File: rtl/fetch_prefetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_prefetch_if #(
    parameter int XLEN = 16,
    parameter int ILEN = 16
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the fetch PC, issues pipelined in-order fetches, buffers them in a
// prefetch queue and feeds the IF/ID register; redirects flush queued and in-flight work.
module fetch_prefetch #(
    parameter int              XLEN      = 16,
    parameter int              ILEN      = 16,
    parameter int              DEPTH     = 4,
    parameter int              PC_STEP   = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [ILEN-1:0] NOP_INSTR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PCSrcE,
    input  logic [XLEN-1:0]        PCTargetE,
    input  logic                   StallD,
    fetch_prefetch_if.master       imem,
    output logic [ILEN-1:0]        InstrD,
    output logic [XLEN-1:0]        PCPlus2D,
    output logic                   ValidD
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
    localparam logic [CW:0]     LIMIT   = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [ILEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pcp   [DEPTH];

    logic credit_ok;
    logic fire;
    logic rsp;
    logic dropping;
    logic push;
    logic pop;

    // Credits cover both buffered and outstanding fetches, so a response always has a slot.
    assign credit_ok = ((CW + 1)'(count) + (CW + 1)'(inflight)) < LIMIT;
    assign imem.imem_req  = !rst && !PCSrcE && credit_ok;
    assign imem.imem_addr = pc_f;

    assign fire     = imem.imem_req && imem.imem_ready;
    assign rsp      = imem.imem_rvalid && (inflight != '0);
    assign dropping = rsp && (drop != '0);
    assign push     = rsp && !dropping && !PCSrcE;
    assign pop      = !StallD && !PCSrcE && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f     <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            head     <= '0;
            tail     <= '0;
            InstrD   <= NOP_INSTR;
            PCPlus2D <= '0;
            ValidD   <= 1'b0;
        end else begin
            inflight <= inflight + CW'(fire) - CW'(rsp);
            if (PCSrcE) begin
                // Everything still outstanding belongs to the wrong path.
                pc_f   <= PCTargetE;
                rsp_pc <= PCTargetE;
                count  <= '0;
                head   <= '0;
                tail   <= '0;
                drop   <= inflight - CW'(rsp);
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end else begin
                if (fire) begin
                    pc_f <= pc_f + STEP;
                end
                if (dropping) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    tail   <= tail + PW'(1);
                    rsp_pc <= rsp_pc + STEP;
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);

                // IF/ID boundary
                if (!StallD) begin
                    if (pop) begin
                        InstrD   <= q_instr[head];
                        PCPlus2D <= q_pcp[head];
                        ValidD   <= 1'b1;
                    end else begin
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem.imem_rdata;
            q_pcp[tail]   <= rsp_pc + STEP;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: latency-configurable memory model and an in-order PC scoreboard.
module tb_fetch_prefetch;
    localparam logic [15:0] KEY = 16'hA5A5;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        PCSrcE = 1'b0;
    logic        StallD = 1'b0;
    logic [15:0] PCTargetE = '0;
    logic [15:0] InstrD, PCPlus2D;
    logic        ValidD;

    logic        PCSrcE2 = 1'b0;
    logic        StallD2 = 1'b0;
    logic [15:0] PCTargetE2 = '0;
    logic [15:0] InstrD2, PCPlus2D2;
    logic        ValidD2;

    fetch_prefetch_if #(.XLEN(16), .ILEN(16)) bus ();
    fetch_prefetch_if #(.XLEN(16), .ILEN(16)) bus2 ();

    fetch_prefetch #(
        .XLEN(16), .ILEN(16), .DEPTH(4), .PC_STEP(2),
        .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem(bus), .InstrD(InstrD), .PCPlus2D(PCPlus2D), .ValidD(ValidD)
    );

    fetch_prefetch #(
        .XLEN(16), .ILEN(16), .DEPTH(4), .PC_STEP(2),
        .RESET_PC(16'hFFFE), .NOP_INSTR(16'h0000)
    ) dut_wrap (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE2), .PCTargetE(PCTargetE2), .StallD(StallD2),
        .imem(bus2), .InstrD(InstrD2), .PCPlus2D(PCPlus2D2), .ValidD(ValidD2)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          edge_n = 0;
    int          lat = 1;
    logic        rdy = 1'b1;
    req_t        pend[$];
    logic        req_seen;
    logic [15:0] addr_seen;
    logic [15:0] addr2_seen;
    logic        fire2 = 1'b0;
    logic [15:0] addr2_q = '0;
    logic [15:0] exp_pc = '0;
    logic [15:0] last_instr = '0;
    logic [15:0] last_pc = '0;
    logic        last_valid = 1'b0;
    int          nbub = 0;
    logic        want_first = 1'b0;
    logic [15:0] first_pc = '0;
    logic        saw_low;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        PCSrcE = 1'b0;
        StallD = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus2.imem_ready = 1'b0;
        bus2.imem_rvalid = 1'b0;
        bus2.imem_rdata = '0;
        pend.delete();
        fire2 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_valid", ValidD, 1'b0);
        chk("rst_instr", InstrD, 16'h0000);
        chk("rst_pcp", PCPlus2D, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 16'h0000;
        last_instr = '0;
        last_pc = '0;
        last_valid = 1'b0;
    endtask

    // One clock: drive inputs, model memory, then score the IF/ID register after the edge.
    task automatic step(input logic redir, input logic [15:0] tgt, input logic stall);
        int due;
        PCSrcE = redir;
        PCTargetE = tgt;
        StallD = stall;
        bus.imem_ready = rdy;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = pend[0].addr ^ KEY;
            void'(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata = '0;
        end
        bus2.imem_ready = 1'b1;
        bus2.imem_rvalid = fire2;
        bus2.imem_rdata = addr2_q ^ KEY;
        #1;
        req_seen = bus.imem_req;
        addr_seen = bus.imem_addr;
        if (bus.imem_req && bus.imem_ready) begin
            due = edge_n + lat;
            if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
            pend.push_back('{addr: bus.imem_addr, due: due});
        end
        addr2_seen = bus2.imem_addr;
        fire2 = bus2.imem_req;
        addr2_q = bus2.imem_addr;
        @(posedge clk);
        edge_n++;
        #1;
        if (redir) begin
            chk("flush_valid", ValidD, 1'b0);
            chk("flush_instr", InstrD, 16'h0000);
            chk("flush_pcp", PCPlus2D, last_pc);
            last_valid = 1'b0;
            last_instr = '0;
            exp_pc = tgt;
        end else if (stall) begin
            chk("stall_valid", ValidD, last_valid);
            chk("stall_instr", InstrD, last_instr);
            chk("stall_pcp", PCPlus2D, last_pc);
        end else if (ValidD) begin
            chk("sb_pcp", PCPlus2D, 16'(exp_pc + 16'd2));
            chk("sb_instr", InstrD, exp_pc ^ KEY);
            last_pc = 16'(exp_pc + 16'd2);
            last_instr = exp_pc ^ KEY;
            last_valid = 1'b1;
            exp_pc = 16'(exp_pc + 16'd2);
            if (want_first) begin
                first_pc = PCPlus2D;
                want_first = 1'b0;
            end
        end else begin
            chk("bubble_instr", InstrD, 16'h0000);
            chk("bubble_pcp", PCPlus2D, last_pc);
            last_valid = 1'b0;
            last_instr = '0;
            nbub++;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release and streaming with latency 1
        lat = 1;
        rdy = 1'b1;
        @(negedge clk);
        do_reset();
        step(1'b0, '0, 1'b0);
        chk("t1_req0", req_seen, 1'b1);
        chk("t1_addr0", addr_seen, 16'h0000);
        chk("t1_wrap_addr0", addr2_seen, 16'hFFFE);
        chk("t1_valid_e1", ValidD, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t1_addr1", addr_seen, 16'h0002);
        chk("t1_wrap_addr1", addr2_seen, 16'h0000);
        chk("t1_valid_e2", ValidD, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t1_first_valid", ValidD, 1'b1);
        chk("t1_first_instr", InstrD, 16'hA5A5);
        chk("t1_first_pcp", PCPlus2D, 16'h0002);
        chk("t1_wrap_pcp0", PCPlus2D2, 16'h0000);
        chk("t1_wrap_instr0", InstrD2, 16'h5A5B);
        step(1'b0, '0, 1'b0);
        chk("t1_wrap_pcp1", PCPlus2D2, 16'h0002);
        chk("t1_wrap_instr1", InstrD2, 16'hA5A5);
        nbub = 0;
        repeat (10) step(1'b0, '0, 1'b0);
        chk("t1_no_gap", nbub, 0);

        // Decode stall mid-stream
        saw_low = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1);
            if (!req_seen) saw_low = 1'b1;
        end
        chk("t2_req_throttle", saw_low, 1'b1);
        nbub = 0;
        repeat (8) step(1'b0, '0, 1'b0);
        chk("t2_no_gap_after", nbub, 0);

        // Back-pressure from memory
        for (int i = 0; i < 8; i++) begin
            rdy = ~rdy;
            step(1'b0, '0, 1'b0);
        end
        rdy = 1'b1;

        // Redirect with two fetches in flight, latency 3
        do_reset();
        lat = 3;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 16'h0100, 1'b0);
        chk("t3_redir_noreq", req_seen, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t3_target_req", req_seen, 1'b1);
        chk("t3_target_addr", addr_seen, 16'h0100);
        first_pc = '0;
        want_first = 1'b1;
        for (int i = 0; i < 12 && want_first; i++) step(1'b0, '0, 1'b0);
        chk("t3_first_pcp", first_pc, 16'h0102);
        repeat (6) step(1'b0, '0, 1'b0);

        // Redirect together with stall and with a response arriving
        lat = 1;
        repeat (6) step(1'b0, '0, 1'b0);
        step(1'b1, 16'h0200, 1'b1);
        first_pc = '0;
        want_first = 1'b1;
        for (int i = 0; i < 12 && want_first; i++) step(1'b0, '0, 1'b0);
        chk("t4_first_pcp", first_pc, 16'h0202);
        repeat (6) step(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
